// File: rtl/io_timer.sv
// io_timer: memory-mapped countdown timer raising a level IRQ on expiry
// Ports: clk, reset (async, active-low); IO_En/IO_WE/IO_Addr[31:2]/IO_WData bus request;
//        IO_RData combinational load data; IRQ = pending & IM.
// Window: off0 CTRL {IM,MODE[1:0],EN}, off1 PRESET, off2 COUNT (read-only), off3 reserved.
module io_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IO_En,
    input  logic        IO_WE,
    input  logic [29:0] IO_Addr,
    input  logic [31:0] IO_WData,
    output logic [31:0] IO_RData,
    output logic        IRQ
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d, count_q, count_d;
    logic        pend_q, pend_d;
    logic        sel, wr_ctrl, wr_preset, en, reload;
    logic [1:0]  off;
    always_comb begin
        // IO_Addr is a word address, so byte bits [31:4] live at [29:2]
        sel       = IO_En && (IO_Addr[29:2] == BASE_ADDR[31:4]);
        off       = IO_Addr[1:0];
        wr_ctrl   = sel && IO_WE && (off == 2'd0);
        wr_preset = sel && IO_WE && (off == 2'd1);
        en        = ctrl_q[0];
        reload    = ctrl_q[2:1] == 2'b01;
        IO_RData  = !sel ? 32'd0 : off == 2'd0 ? {28'd0, ctrl_q} : off == 2'd1 ? preset_q :
                    off == 2'd2 ? count_q : 32'd0;
        IRQ       = pend_q & ctrl_q[3];
        state_d   = state_q;
        count_d   = count_q;
        case (state_q)
            IDLE: state_d = en ? LOAD : IDLE;
            LOAD: begin
                state_d = en ? CNT : IDLE;
                count_d = en ? preset_q : count_q;
            end
            CNT: begin
                // COUNT<=1 covers PRESET=0, so the counter never wraps
                state_d = !en ? IDLE : count_q <= 32'd1 ? INT : CNT;
                count_d = !en ? count_q : count_q <= 32'd1 ? 32'd0 : count_q - 32'd1;
            end
            default: state_d = (en && reload) ? LOAD : IDLE;
        endcase
        // a CTRL write overrides the FSM's own updates of CTRL and the pending flag
        ctrl_d   = wr_ctrl ? IO_WData[3:0] : (state_q == INT && !reload) ? {ctrl_q[3:1], 1'b0} : ctrl_q;
        pend_d   = wr_ctrl ? 1'b0 : (state_q == CNT && state_d == INT) ? 1'b1 :
                   (state_q == INT && reload) ? 1'b0 : pend_q;
        preset_d = wr_preset ? IO_WData : preset_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed and randomized checks of io_timer against a timeline model
module tb_io_timer;
    localparam logic [29:0] WIN = 30'h0000_1FC0;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IO_En = 1'b0;
    logic        IO_WE = 1'b0;
    logic [29:0] IO_Addr = 30'd0;
    logic [31:0] IO_WData = 32'd0;
    logic [31:0] IO_RData;
    logic        IRQ;
    int          vectors = 0;
    int          errors = 0;

    io_timer dut (
        .clk(clk), .reset(reset), .IO_En(IO_En), .IO_WE(IO_WE), .IO_Addr(IO_Addr),
        .IO_WData(IO_WData), .IO_RData(IO_RData), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // Model: m_pos is the position in the timer's timeline since enable
    // (0 idle, 1 load, 2.. counting, 2+max(n,1) expiry cycle), n = PRESET captured at load.
    logic [3:0]  m_ctrl, n_ctrl;
    logic [31:0] m_preset, n_preset, m_count, n_count, exp_rd;
    logic        m_pend, n_pend, m_sel, m_rl, wrc, wrp, exp_irq;
    logic [1:0]  m_off;
    int          m_pos, n_pos, m_n, n_n, ip, nip;

    always_comb begin
        m_sel    = IO_En && (IO_Addr[29:2] == WIN[29:2]);
        m_off    = IO_Addr[1:0];
        wrc      = m_sel && IO_WE && m_off == 2'd0;
        wrp      = m_sel && IO_WE && m_off == 2'd1;
        m_rl     = m_ctrl[2:1] == 2'b01;
        ip       = 2 + (m_n == 0 ? 1 : m_n);
        if (m_pos == 0) n_pos = m_ctrl[0] ? 1 : 0;
        else if (!m_ctrl[0]) n_pos = 0;
        else if (m_pos == ip) n_pos = m_rl ? 1 : 0;
        else n_pos = m_pos + 1;
        n_n      = (m_pos == 1 && n_pos == 2) ? int'(m_preset) : m_n;
        nip      = 2 + (n_n == 0 ? 1 : n_n);
        n_count  = m_count;
        if (n_pos >= 2 && n_pos < nip) n_count = 32'(n_n - (n_pos - 2));
        else if (n_pos == nip) n_count = 32'd0;
        n_pend   = wrc ? 1'b0 : (n_pos == nip) ? 1'b1 : (m_pos == ip && m_rl) ? 1'b0 : m_pend;
        n_ctrl   = wrc ? IO_WData[3:0] : (m_pos == ip && !m_rl) ? {m_ctrl[3:1], 1'b0} : m_ctrl;
        n_preset = wrp ? IO_WData : m_preset;
        exp_rd   = !m_sel ? 32'd0 : m_off == 2'd0 ? {28'd0, m_ctrl} : m_off == 2'd1 ? m_preset :
                   m_off == 2'd2 ? m_count : 32'd0;
        exp_irq  = m_pend & m_ctrl[3];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ctrl <= 4'd0; m_preset <= 32'd0; m_count <= 32'd0; m_pend <= 1'b0; m_pos <= 0; m_n <= 0;
        end else begin
            m_ctrl <= n_ctrl; m_preset <= n_preset; m_count <= n_count; m_pend <= n_pend;
            m_pos <= n_pos; m_n <= n_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
        IO_En = 1'b1; IO_WE = 1'b1; IO_Addr = a; IO_WData = d;
        tick();
        IO_En = 1'b0; IO_WE = 1'b0;
    endtask

    task automatic set_read(input logic [1:0] off);
        IO_En = 1'b1; IO_WE = 1'b0; IO_Addr = {WIN[29:2], off};
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #3;
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", IRQ); end
        for (int o = 0; o < 3; o++) begin
            set_read(2'(o));
            vectors++;
            if (IO_RData !== 32'd0) begin errors++; $display("FAIL reset_reg off%0d got %h exp 0", o, IO_RData); end
        end
        IO_En = 1'b0;
        @(negedge clk) reset = 1'b1;
        tick();
    endtask

    task automatic test_oneshot();
        bus_write({WIN[29:2], 2'd1}, 32'd5);
        bus_write({WIN[29:2], 2'd0}, 32'h9);
        set_read(2'd2);
        for (int k = 1; k <= 9; k++) begin
            tick();
            vectors++;
            if (IO_RData !== ((k >= 2 && k <= 7) ? 32'(7 - k) : 32'd0)) begin
                errors++; $display("FAIL oneshot_count k=%0d got %0d exp %0d", k, IO_RData, (k >= 2 && k <= 7) ? 7 - k : 0);
            end
            vectors++;
            if (IRQ !== (k >= 7)) begin errors++; $display("FAIL oneshot_irq k=%0d got %b exp %b", k, IRQ, k >= 7); end
        end
        set_read(2'd0);
        vectors++; if (IO_RData !== 32'h8) begin errors++; $display("FAIL oneshot_en_clr got %h exp 8", IO_RData); end
        bus_write({WIN[29:2], 2'd0}, 32'h8);
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL oneshot_ack got %b exp 0", IRQ); end
    endtask

    task automatic test_autoreload();
        int pulses = 0;
        bus_write({WIN[29:2], 2'd1}, 32'd3);
        bus_write({WIN[29:2], 2'd0}, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            tick();
            pulses += int'(IRQ);
            vectors++;
            if (IRQ !== (k % 5 == 0)) begin errors++; $display("FAIL reload_irq k=%0d got %b exp %b", k, IRQ, k % 5 == 0); end
        end
        vectors++; if (pulses != 4) begin errors++; $display("FAIL reload_pulses got %0d exp 4", pulses); end
        bus_write({WIN[29:2], 2'd0}, 32'h0);
    endtask

    task automatic test_masked();
        bus_write({WIN[29:2], 2'd1}, 32'd2);
        bus_write({WIN[29:2], 2'd0}, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL masked_irq k=%0d got %b exp 0", k, IRQ); end
        end
        set_read(2'd0);
        vectors++; if (IO_RData !== 32'h0) begin errors++; $display("FAIL masked_en_clr got %h exp 0", IO_RData); end
        bus_write({WIN[29:2], 2'd0}, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL masked_rewrite k=%0d got %b exp 0", k, IRQ); end
            tick();
        end
        bus_write({WIN[29:2], 2'd0}, 32'h0);
    endtask

    task automatic test_preset_zero();
        bus_write({WIN[29:2], 2'd1}, 32'd0);
        bus_write({WIN[29:2], 2'd0}, 32'h9);
        set_read(2'd2);
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++; if (IO_RData !== 32'd0) begin errors++; $display("FAIL zero_count k=%0d got %0d exp 0", k, IO_RData); end
            vectors++; if (IRQ !== (k >= 3)) begin errors++; $display("FAIL zero_irq k=%0d got %b exp %b", k, IRQ, k >= 3); end
        end
        bus_write({WIN[29:2], 2'd0}, 32'h0);
    endtask

    task automatic test_reset_midcount();
        bus_write({WIN[29:2], 2'd1}, 32'd30);
        bus_write({WIN[29:2], 2'd0}, 32'h9);
        set_read(2'd2);
        for (int k = 1; k <= 15; k++) tick();
        vectors++; if (IO_RData !== 32'd17) begin errors++; $display("FAIL mid_count got %0d exp 17", IO_RData); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL async_irq got %b exp 0", IRQ); end
        vectors++; if (IO_RData !== 32'd0) begin errors++; $display("FAIL async_count got %0d exp 0", IO_RData); end
        set_read(2'd0);
        vectors++; if (IO_RData !== 32'd0) begin errors++; $display("FAIL async_ctrl got %h exp 0", IO_RData); end
        @(negedge clk) reset = 1'b1;
        set_read(2'd2);
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++;
            if (IRQ !== 1'b0 || IO_RData !== 32'd0) begin
                errors++; $display("FAIL post_reset k=%0d irq %b count %0d exp 0 0", k, IRQ, IO_RData);
            end
        end
        IO_En = 1'b0;
    endtask

    task automatic test_bad_access();
        bus_write({WIN[29:2], 2'd1}, 32'h1234);
        bus_write({WIN[29:2], 2'd0}, 32'h4);
        bus_write({WIN[29:2], 2'd2}, 32'hDEAD_BEEF);
        bus_write({WIN[29:2], 2'd3}, 32'hDEAD_BEEF);
        bus_write(WIN + 30'd4, 32'hF);
        bus_write(WIN + 30'd5, 32'h5555);
        IO_En = 1'b0; IO_WE = 1'b1; IO_Addr = WIN; IO_WData = 32'hF;
        tick();
        IO_WE = 1'b0; IO_En = 1'b1; IO_Addr = WIN + 30'd5;
        #1;
        vectors++; if (IO_RData !== 32'd0) begin errors++; $display("FAIL outside_read got %h exp 0", IO_RData); end
        IO_En = 1'b0; IO_Addr = {WIN[29:2], 2'd1};
        #1;
        vectors++; if (IO_RData !== 32'd0) begin errors++; $display("FAIL no_en_read got %h exp 0", IO_RData); end
        set_read(2'd3);
        vectors++; if (IO_RData !== 32'd0) begin errors++; $display("FAIL reserved_read got %h exp 0", IO_RData); end
        set_read(2'd0);
        vectors++; if (IO_RData !== 32'h4) begin errors++; $display("FAIL bad_ctrl got %h exp 4", IO_RData); end
        set_read(2'd1);
        vectors++; if (IO_RData !== 32'h1234) begin errors++; $display("FAIL bad_preset got %h exp 1234", IO_RData); end
        set_read(2'd2);
        vectors++; if (IO_RData !== 32'd0) begin errors++; $display("FAIL bad_count got %h exp 0", IO_RData); end
        IO_En = 1'b0;
    endtask

    task automatic test_random();
        logic [29:0] a;
        for (int i = 0; i < 600; i++) begin
            int r = int'($urandom_range(0, 19));
            IO_En = 1'b1; IO_WE = 1'b0; IO_WData = $urandom;
            IO_Addr = {WIN[29:2], 2'($urandom_range(0, 3))};
            if (r == 0) begin
                IO_WE = 1'b1; IO_Addr = {WIN[29:2], 2'd0};
            end else if (r == 1) begin
                IO_WE = 1'b1; IO_Addr = {WIN[29:2], 2'd1}; IO_WData = $urandom_range(0, 6);
            end else if (r == 2) begin
                IO_WE = 1'b1; IO_WData = $urandom_range(0, 15);
            end else if (r == 3) begin
                a = 30'($urandom);
                if (a[29:2] == WIN[29:2]) a[10] = ~a[10];
                IO_WE = 1'b1; IO_Addr = a;
            end else if (r >= 16) begin
                IO_En = 1'b0; IO_WE = r[0];
            end
            #1;
            vectors++;
            if (IO_RData !== exp_rd || IRQ !== exp_irq) begin
                errors++; $display("FAIL random i=%0d rdata %h irq %b exp %h %b", i, IO_RData, IRQ, exp_rd, exp_irq);
            end
            tick();
        end
        IO_En = 1'b0; IO_WE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_preset_zero();
        test_reset_midcount();
        test_bad_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
